// File: rtl/sregfile_dump_reader.sv
// Walks x0..x(NUM_REGS-1) through a shared regfile read port and streams
// {index, data} beats to debug logic over a valid/ready interface.
module sregfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  port_busy_i,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADDR_WIDTH-1:0] m_index_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_nextIdx;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_index <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
      if (w_capture) begin
        r_index <= r_idx;
        r_data  <= rf_data_i;
      end
    end
  end

  // Abort outranks capture, handshake and start; every return to IDLE
  // rewinds idx so the read address sits at 0 while idle.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          w_nextState = S_FETCH;
          w_nextIdx   = '0;
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          w_nextState = S_IDLE;
          w_nextIdx   = '0;
        end else if (!port_busy_i) begin
          w_capture   = 1'b1;
          w_nextState = S_SEND;
        end
      end
      S_SEND: begin
        if (abort_i) begin
          w_nextState = S_IDLE;
          w_nextIdx   = '0;
        end else if (m_ready_i) begin
          if (r_idx == LAST_IDX) begin
            w_nextState = S_DONE;
          end else begin
            w_nextIdx   = r_idx + ONE_IDX;
            w_nextState = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
        w_nextIdx   = '0;
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextIdx   = '0;
      end
    endcase
  end

  assign rf_addr_o = r_idx;
  assign m_valid_o = (r_state == S_SEND);
  assign m_index_o = r_index;
  assign m_data_o  = r_data;
  assign m_last_o  = m_valid_o && (r_index == LAST_IDX);
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_DONE);

endmodule

// File: tb/tb_sregfile_dump_reader.sv
// Self-checking bench for sregfile_dump_reader: a behavioural regfile plus an
// expected-beat model (index k carries x_k, x0 reads as 0) checked per scenario.
module tb_sregfile_dump_reader;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          port_busy_i = 1'b0;
  logic          m_ready_i = 1'b0;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_data_i;
  logic          m_valid_o;
  logic [AW-1:0] m_index_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] regs [NR];

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int beatIdx[$];
  logic [DW-1:0] beatData[$];
  int doneCycles[$];
  int lastHsCycle = -1;
  int lastViol = 0;
  int stableViol = 0;
  bit prevPending = 1'b0;
  bit prevAbort = 1'b0;
  logic [AW-1:0] prevIdx = '0;
  logic [DW-1:0] prevData = '0;

  sregfile_dump_reader #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .port_busy_i(port_busy_i), .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_index_o(m_index_o),
    .m_data_o(m_data_o), .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  assign rf_data_i = (rf_addr_o == '0) ? '0 : regs[rf_addr_o];

  function automatic logic [DW-1:0] expData(int k);
    return (k == 0) ? '0 : regs[k];
  endfunction

  always @(posedge clk) cycleCount++;

  // Negedge monitor: records accepted beats and done pulses, and tallies
  // last-flag and hold-while-stalled rule breaks for the tests to judge.
  always @(negedge clk) begin
    if (m_last_o !== (m_valid_o && (m_index_o == AW'(NR - 1)))) lastViol++;
    if (prevPending && rst_n && !prevAbort &&
        (m_valid_o !== 1'b1 || m_index_o !== prevIdx || m_data_o !== prevData)) stableViol++;
    if (m_valid_o && m_ready_i && !abort_i) begin
      beatIdx.push_back(int'(m_index_o));
      beatData.push_back(m_data_o);
      if (m_index_o == AW'(NR - 1)) lastHsCycle = cycleCount;
    end
    if (done_o) doneCycles.push_back(cycleCount);
    prevPending = m_valid_o && !m_ready_i;
    prevAbort   = abort_i;
    prevIdx     = m_index_o;
    prevData    = m_data_o;
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearMon();
    beatIdx.delete();
    beatData.delete();
    doneCycles.delete();
    lastHsCycle = -1;
    lastViol = 0;
    stableViol = 0;
  endtask

  task automatic startDump(output int sc);
    start_i = 1'b1;
    sc = cycleCount;
    stepCycles(1);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    int n = 0;
    while (!done_o && n < budget) begin
      stepCycles(1);
      n++;
    end
    ok = done_o;
  endtask

  task automatic waitBeat(input int index, input int budget, output bit ok);
    int n = 0;
    while (!(m_valid_o && int'(m_index_o) == index) && n < budget) begin
      stepCycles(1);
      n++;
    end
    ok = m_valid_o && int'(m_index_o) == index;
  endtask

  task automatic waitFetch(input int index, input int budget, output bit ok);
    int n = 0;
    while (!(busy_o && !m_valid_o && !done_o && int'(rf_addr_o) == index) && n < budget) begin
      stepCycles(1);
      n++;
    end
    ok = busy_o && !m_valid_o && !done_o && int'(rf_addr_o) == index;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    stepCycles(2);
    checks++;
    if ({rf_addr_o, m_valid_o, m_index_o, m_data_o, m_last_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got addr=%0h valid=%b idx=%0h data=%0h busy=%b done=%b, expected all 0",
               rf_addr_o, m_valid_o, m_index_o, m_data_o, busy_o, done_o);
    end
    rst_n = 1'b1;
    stepCycles(2);
    checks++;
    if ({m_valid_o, busy_o, done_o, rf_addr_o} !== '0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got valid=%b busy=%b done=%b addr=%0h, expected 0",
               m_valid_o, busy_o, done_o, rf_addr_o);
    end
  endtask

  task automatic test_full_dump();
    int sc;
    int nBad = 0;
    bit ok;
    m_ready_i = 1'b1;
    clearMon();
    startDump(sc);
    waitDone(200, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL full_done_timeout: got no done, expected done"); end
    stepCycles(1);
    for (int k = 0; k < beatIdx.size(); k++)
      if (beatIdx[k] != k || beatData[k] !== expData(k)) nBad++;
    checks++;
    if (beatIdx.size() != NR || nBad != 0) begin
      failures++;
      $display("[TB] FAIL full_beats: got %0d beats (%0d wrong), expected %0d in order", beatIdx.size(), nBad, NR);
    end
    checks++;
    if (doneCycles.size() != 1 || doneCycles[0] != sc + 65) begin
      failures++;
      $display("[TB] FAIL full_done_cycle: got %0d pulses first at %0d, expected 1 at %0d",
               doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1, sc + 65);
    end
    checks++;
    if (doneCycles.size() == 0 || doneCycles[0] != lastHsCycle + 1) begin
      failures++;
      $display("[TB] FAIL full_done_after_last: got last hs %0d, expected done one cycle later", lastHsCycle);
    end
    checks++;
    if (lastViol != 0) begin failures++; $display("[TB] FAIL full_last_flag: got %0d bad cycles, expected 0", lastViol); end
    checks++;
    if (busy_o !== 1'b0 || rf_addr_o !== '0) begin
      failures++;
      $display("[TB] FAIL full_back_idle: got busy=%b addr=%0h, expected 0 0", busy_o, rf_addr_o);
    end
  endtask

  task automatic test_backpressure();
    int sc;
    int nBad = 0;
    bit ok;
    m_ready_i = 1'b1;
    clearMon();
    startDump(sc);
    waitBeat(3, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL bp_beat3_timeout: got none, expected index 3 beat"); end
    m_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      stepCycles(1);
      checks++;
      if (m_valid_o !== 1'b1 || m_index_o !== AW'(3) || m_data_o !== 32'h1000_0003) begin
        failures++;
        $display("[TB] FAIL bp_hold: got valid=%b idx=%0d data=%0h, expected 1 3 10000003", m_valid_o, m_index_o, m_data_o);
      end
    end
    m_ready_i = 1'b1;
    waitDone(200, ok);
    stepCycles(1);
    for (int k = 0; k < beatIdx.size(); k++)
      if (beatIdx[k] != k || beatData[k] !== expData(k)) nBad++;
    checks++;
    if (!ok || beatIdx.size() != NR || nBad != 0 || stableViol != 0) begin
      failures++;
      $display("[TB] FAIL bp_beats: got done=%b %0d beats (%0d wrong, %0d unstable), expected %0d clean",
               ok, beatIdx.size(), nBad, stableViol, NR);
    end
  endtask

  task automatic test_port_busy();
    int sc;
    int nBad = 0;
    bit ok;
    m_ready_i = 1'b1;
    clearMon();
    startDump(sc);
    waitFetch(7, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL pb_fetch7_timeout: got none, expected fetch of idx 7"); end
    port_busy_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      stepCycles(1);
      checks++;
      if (m_valid_o !== 1'b0 || rf_addr_o !== AW'(7) || busy_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL pb_hold: got valid=%b addr=%0d busy=%b, expected 0 7 1", m_valid_o, rf_addr_o, busy_o);
      end
    end
    port_busy_i = 1'b0;
    stepCycles(1);
    checks++;
    if (m_valid_o !== 1'b1 || m_index_o !== AW'(7) || m_data_o !== 32'h1000_0007) begin
      failures++;
      $display("[TB] FAIL pb_release: got valid=%b idx=%0d data=%0h, expected 1 7 10000007", m_valid_o, m_index_o, m_data_o);
    end
    waitDone(200, ok);
    stepCycles(1);
    for (int k = 0; k < beatIdx.size(); k++)
      if (beatIdx[k] != k || beatData[k] !== expData(k)) nBad++;
    checks++;
    if (!ok || beatIdx.size() != NR || nBad != 0) begin
      failures++;
      $display("[TB] FAIL pb_beats: got done=%b %0d beats (%0d wrong), expected %0d", ok, beatIdx.size(), nBad, NR);
    end
  endtask

  task automatic test_abort();
    int sc;
    int nBad = 0;
    bit ok;
    m_ready_i = 1'b1;
    clearMon();
    startDump(sc);
    waitBeat(10, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL ab_beat10_timeout: got none, expected index 10 beat"); end
    m_ready_i = 1'b0;
    abort_i = 1'b1;
    stepCycles(1);
    abort_i = 1'b0;
    checks++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ab_idle: got valid=%b busy=%b, expected 0 0", m_valid_o, busy_o);
    end
    stepCycles(3);
    checks++;
    if (doneCycles.size() != 0 || beatIdx.size() != 10) begin
      failures++;
      $display("[TB] FAIL ab_no_done: got %0d done pulses %0d beats, expected 0 and 10", doneCycles.size(), beatIdx.size());
    end
    start_i = 1'b1;
    abort_i = 1'b1;
    stepCycles(1);
    start_i = 1'b0;
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL ab_start_and_abort: got busy=%b, expected 0", busy_o); end
    m_ready_i = 1'b1;
    startDump(sc);
    waitBeat(2, 20, ok);
    abort_i = 1'b1;
    stepCycles(1);
    abort_i = 1'b0;
    checks++;
    if (!ok || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ab_over_handshake: got beat2=%b busy=%b valid=%b, expected 1 0 0", ok, busy_o, m_valid_o);
    end
    stepCycles(1);
    clearMon();
    startDump(sc);
    waitDone(200, ok);
    stepCycles(1);
    for (int k = 0; k < beatIdx.size(); k++)
      if (beatIdx[k] != k || beatData[k] !== expData(k)) nBad++;
    checks++;
    if (!ok || beatIdx.size() != NR || nBad != 0) begin
      failures++;
      $display("[TB] FAIL ab_restart: got done=%b %0d beats (%0d wrong) first=%0d, expected %0d from 0",
               ok, beatIdx.size(), nBad, (beatIdx.size() > 0) ? beatIdx[0] : -1, NR);
    end
  endtask

  task automatic test_start_ignored();
    int sc;
    int nBad = 0;
    bit ok;
    m_ready_i = 1'b1;
    clearMon();
    startDump(sc);
    waitBeat(5, 30, ok);
    start_i = 1'b1;
    stepCycles(1);
    start_i = 1'b0;
    waitDone(200, ok);
    start_i = 1'b1;
    stepCycles(1);
    start_i = 1'b0;
    checks++;
    if (!ok || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL si_start_in_done: got done=%b busy=%b, expected 1 0", ok, busy_o);
    end
    for (int k = 0; k < beatIdx.size(); k++)
      if (beatIdx[k] != k || beatData[k] !== expData(k)) nBad++;
    checks++;
    if (beatIdx.size() != NR || nBad != 0 || doneCycles.size() != 1 || doneCycles[0] != sc + 65) begin
      failures++;
      $display("[TB] FAIL si_beats: got %0d beats (%0d wrong) %0d done, expected %0d and 1 done at %0d",
               beatIdx.size(), nBad, doneCycles.size(), NR, sc + 65);
    end
  endtask

  task automatic test_reset_mid_dump();
    int sc;
    int nBad = 0;
    bit ok;
    m_ready_i = 1'b1;
    clearMon();
    startDump(sc);
    waitBeat(20, 80, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {rf_addr_o, m_valid_o, m_index_o, m_data_o, m_last_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("[TB] FAIL rm_async: got beat20=%b addr=%0h valid=%b idx=%0h data=%0h busy=%b, expected all 0",
               ok, rf_addr_o, m_valid_o, m_index_o, m_data_o, busy_o);
    end
    stepCycles(2);
    rst_n = 1'b1;
    stepCycles(1);
    clearMon();
    startDump(sc);
    waitDone(200, ok);
    stepCycles(1);
    for (int k = 0; k < beatIdx.size(); k++)
      if (beatIdx[k] != k || beatData[k] !== expData(k)) nBad++;
    checks++;
    if (!ok || beatIdx.size() != NR || nBad != 0) begin
      failures++;
      $display("[TB] FAIL rm_restart: got done=%b %0d beats (%0d wrong), expected %0d from index 0", ok, beatIdx.size(), nBad, NR);
    end
  endtask

  task automatic test_random();
    int sc;
    int nBad;
    int n;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      clearMon();
      m_ready_i = 1'b1;
      startDump(sc);
      n = 0;
      while (!done_o && n < 2000) begin
        m_ready_i = 1'($urandom_range(0, 1));
        port_busy_i = ($urandom_range(0, 2) == 0);
        stepCycles(1);
        n++;
      end
      checks++;
      if (!done_o) begin failures++; $display("[TB] FAIL rnd_timeout: got no done in iteration %0d, expected done", it); end
      port_busy_i = 1'b0;
      m_ready_i = 1'b1;
      stepCycles(1);
      nBad = 0;
      for (int k = 0; k < beatIdx.size(); k++)
        if (beatIdx[k] != k || beatData[k] !== expData(k)) nBad++;
      checks++;
      if (beatIdx.size() != NR || nBad != 0 || lastViol != 0 || stableViol != 0 || doneCycles.size() != 1) begin
        failures++;
        $display("[TB] FAIL rnd_beats: iter %0d got %0d beats (%0d wrong, last %0d, unstable %0d, done %0d), expected %0d clean, 1 done",
                 it, beatIdx.size(), nBad, lastViol, stableViol, doneCycles.size(), NR);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_port_busy();
    test_abort();
    test_start_ignored();
    test_reset_mid_dump();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
